// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, branch redirect and decode handoff.
// master = fetch unit side, slave = memory / branch control / decode side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited word requests, buffers PC-tagged responses for decode.
// Response-to-inst_valid latency one cycle; requests stall while FIFO entries plus in-flight requests reach DEPTH.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [31:0] data_mem_q [DEPTH];
  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] tag_mem_q  [DEPTH];

  logic [CW:0] credit_used;
  logic        req_valid, req_fire, resp_ok, resp_keep, pop;

  assign credit_used = {1'b0, occ_q} + {1'b0, outst_q};
  assign req_valid   = !reset && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign req_fire    = req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok     = bus.imem_resp_valid && (outst_q != '0);
  assign resp_keep   = resp_ok && (drop_q == '0);
  assign pop         = bus.inst_valid && bus.inst_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = (occ_q != '0);
  assign bus.inst_data      = bus.inst_valid ? data_mem_q[rd_ptr_q] : 32'h0;
  assign bus.inst_pc        = bus.inst_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;

    if (bus.redirect_valid) begin
      // Everything still in flight belongs to the old path and must be dropped on return.
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      occ_d      = '0;
      rd_ptr_d   = wr_ptr_q;
      outst_d    = outst_q - CW'(resp_ok);
      drop_d     = outst_q - CW'(resp_ok);
      if (resp_ok) tag_rd_d = tag_rd_q + AW'(1);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wr_d   = tag_wr_q + AW'(1);
      end
      if (resp_ok) begin
        tag_rd_d = tag_rd_q + AW'(1);
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else              wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      outst_d = outst_q + CW'(req_fire) - CW'(resp_ok);
      occ_d   = occ_q + CW'(resp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem_q[tag_wr_q] <= fetch_pc_q;
    if (resp_keep && !bus.redirect_valid) begin
      data_mem_q[wr_ptr_q] <= bus.imem_resp_data;
      pc_mem_q[wr_ptr_q]   <= tag_mem_q[tag_rd_q];
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with programmable delay, expected request/instruction
// queues filled by the stimulus and drained by an independent monitor.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_fire = 0;
  int n_pop = 0;
  int bf, bp;

  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          last_due = 0;

  logic        ctl_req_ready = 1'b0;
  logic        ctl_inst_ready = 1'b0;
  logic        ctl_redirect = 1'b0;
  logic [31:0] ctl_redirect_pc = 32'h0;
  bit          rnd_mode = 1'b0;
  int          dly_min = 1;
  int          dly_max = 1;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_seq(logic [31:0] start, int n);
    logic [31:0] a = start;
    for (int i = 0; i < n; i++) begin
      exp_req.push_back(a);
      exp_pc.push_back(a);
      a = a + 32'd4;
    end
  endtask

  task automatic wait_fire(int target, int budget, string name);
    int b = budget;
    while (n_fire < target && b > 0) begin
      @(posedge clk);
      b--;
    end
    vectors++;
    if (n_fire < target) begin
      miscompares++;
      $display("FAIL %s: timed out with %0d requests, needed %0d", name, n_fire, target);
    end
  endtask

  task automatic wait_pop(int target, int budget, string name);
    int b = budget;
    while (n_pop < target && b > 0) begin
      @(posedge clk);
      b--;
    end
    vectors++;
    if (n_pop < target) begin
      miscompares++;
      $display("FAIL %s: timed out with %0d instructions, needed %0d", name, n_pop, target);
    end
  endtask

  // Asserts reset mid-cycle, checks outputs collapse at once, releases just after a rising edge.
  task automatic do_reset(string name);
    #3;
    reset = 1'b1;
    #1;
    check({name, "_req_valid"}, 32'(bus.imem_req_valid), 32'h0);
    check({name, "_inst_valid"}, 32'(bus.inst_valid), 32'h0);
    check({name, "_inst_data"}, bus.inst_data, 32'h0);
    check({name, "_inst_pc"}, bus.inst_pc, 32'h0);
    exp_req.delete();
    exp_pc.delete();
    ctl_req_ready  = 1'b0;
    ctl_inst_ready = 1'b0;
    ctl_redirect   = 1'b0;
    rnd_mode       = 1'b0;
    dly_min        = 1;
    dly_max        = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory and input driver: all inputs change on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      mem_addr.delete();
      mem_due.delete();
      last_due = 0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = 32'h0;
      bus.inst_ready      = 1'b0;
    end else begin
      bus.redirect_valid = ctl_redirect;
      bus.redirect_pc    = ctl_redirect_pc;
      bus.imem_req_ready = rnd_mode ? ($urandom_range(0, 1) == 1) : ctl_req_ready;
      bus.inst_ready     = rnd_mode ? ($urandom_range(0, 3) != 0) : ctl_inst_ready;
      if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_word(mem_addr.pop_front());
        void'(mem_due.pop_front());
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
      end
      #1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        int due;
        due = cyc + $urandom_range(dly_min, dly_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_addr.push_back(bus.imem_req_addr);
        mem_due.push_back(due);
      end
    end
  end

  // Monitor: every request and every delivered instruction is checked against the queues.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        n_fire++;
        if (exp_req.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL req_addr: unexpected request at %h", bus.imem_req_addr);
        end else begin
          check("req_addr", bus.imem_req_addr, exp_req.pop_front());
        end
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
        n_pop++;
        if (exp_pc.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL inst_pc: unexpected instruction pc %h", bus.inst_pc);
        end else begin
          logic [31:0] p;
          p = exp_pc.pop_front();
          check("inst_pc", bus.inst_pc, p);
          check("inst_data", bus.inst_data, mem_word(p));
        end
      end
    end
  end

  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.inst_ready      = 1'b0;

    // Streaming fetch from RESET_PC with one-cycle memory.
    do_reset("rst0");
    ctl_req_ready = 1'b1; ctl_inst_ready = 1'b1;
    push_seq(RESET_PC, 64);
    bp = n_pop;
    wait_pop(bp + 12, 200, "t1_stream");

    // Decode stalled: credits stop issue at two; one pop frees exactly one request.
    do_reset("rst1");
    ctl_req_ready = 1'b1;
    push_seq(RESET_PC, 16);
    bf = n_fire;
    repeat (8) @(posedge clk);
    #1;
    check("t2_fires", n_fire - bf, 32'd2);
    check("t2_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("t2_head_pc", bus.inst_pc, 32'h0);
    ctl_inst_ready = 1'b1;
    @(posedge clk);
    ctl_inst_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t2_fires_after", n_fire - bf, 32'd3);
    check("t2_head_pc_after", bus.inst_pc, 32'h4);
    check("t2_inst_valid", 32'(bus.inst_valid), 32'h1);

    // Redirect with 0x8 and 0xC in flight: both dropped, fetch restarts at 0x100.
    do_reset("rst2");
    ctl_req_ready = 1'b1; ctl_inst_ready = 1'b1; dly_min = 6; dly_max = 6;
    push_seq(RESET_PC, 4);
    bf = n_fire;
    wait_fire(bf + 4, 100, "t3_fill");
    exp_req.delete(); exp_pc.delete();
    push_seq(32'h100, 16);
    ctl_redirect = 1'b1; ctl_redirect_pc = 32'h103;
    @(posedge clk);
    ctl_redirect = 1'b0;
    bp = n_pop;
    wait_pop(bp + 4, 200, "t3_new_path");

    // Redirect coinciding with a response and a decode pop.
    do_reset("rst3");
    ctl_req_ready = 1'b1; ctl_inst_ready = 1'b1;
    push_seq(RESET_PC, 4);
    bf = n_fire;
    wait_fire(bf + 4, 100, "t4_fill");
    exp_req.delete(); exp_pc.delete();
    push_seq(32'h200, 16);
    ctl_redirect = 1'b1; ctl_redirect_pc = 32'h200;
    @(negedge clk);
    #3;
    check("t4_resp_same_cycle", 32'(bus.imem_resp_valid), 32'h1);
    check("t4_pop_same_cycle", 32'(bus.inst_valid), 32'h1);
    @(posedge clk);
    ctl_redirect = 1'b0;
    #1;
    check("t4_flushed", 32'(bus.inst_valid), 32'h0);
    @(posedge clk);
    #1;
    check("t4_still_empty", 32'(bus.inst_valid), 32'h0);
    bp = n_pop;
    wait_pop(bp + 3, 100, "t4_new_path");

    // Random ready/latency across the 32-bit PC wrap.
    do_reset("rst4");
    ctl_redirect = 1'b1; ctl_redirect_pc = 32'hFFFF_FF00;
    rnd_mode = 1'b1; dly_min = 1; dly_max = 3;
    push_seq(32'hFFFF_FF00, 1100);
    @(posedge clk);
    ctl_redirect = 1'b0;
    bp = n_pop;
    wait_pop(bp + 1000, 20000, "t5_random");
    rnd_mode = 1'b0;

    // Reset with a full FIFO, then restart from RESET_PC.
    do_reset("rst5");
    ctl_req_ready = 1'b1; dly_min = 3; dly_max = 3;
    push_seq(RESET_PC, 8);
    bf = n_fire;
    wait_fire(bf + 2, 50, "t6_fill");
    repeat (10) @(posedge clk);
    #1;
    check("t6_full_head", 32'(bus.inst_valid), 32'h1);
    @(posedge clk);
    do_reset("t6_midop");
    ctl_req_ready = 1'b1;
    push_seq(RESET_PC, 4);
    bf = n_fire;
    wait_fire(bf + 1, 20, "t6_restart");
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
